csa_final_adder: RTL and testbench

- Final carry-propagate stage of the multiplier datapath, directly downstream of the 3:2 compressor tree.
- Consumes the redundant sum/carry vector pair left after the last compression level and resolves it into a single binary result.
- Two-stage pipeline (lower half, then upper half with registered carry) with a valid/ready handshake, so the posit normalisation logic downstream can apply backpressure.
- A tag travels alongside each operation for in-order bookkeeping.

---
 rtl/csa_final_adder_if.sv | 43 ++++
 rtl/csa_final_adder.sv | 85 ++++++++
 tb/tb_csa_final_adder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_final_adder_if.sv
// Handshake bundle for the final carry-propagate adder.
// Input side: in_*; output side: out_*.
interface csa_final_adder_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_sum,
    input  in_carry,
    input  in_tag,
    output out_valid,
    input  out_ready,
    output out_result,
    output out_tag,
    output out_zero
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_sum,
    output in_carry,
    output in_tag,
    input  out_valid,
    output out_ready,
    input  out_result,
    input  out_tag,
    input  out_zero
  );
endinterface

// File: rtl/csa_final_adder.sv
// Resolves a compressor-tree sum/carry pair into binary.
// Two stages: low half first, upper half with carry.
module csa_final_adder #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  csa_final_adder_if.slave  bus
);
  localparam int H = WIDTH / 2;

  logic             s1_en;
  logic             s2_en;

  logic             s1_valid_q;
  logic [H:0]       s1_lo_q;
  logic [H-1:0]     s1_us_q;
  logic [H-1:0]     s1_uc_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q;
  logic [WIDTH:0]   out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_zero_q;

  logic [H:0]       lo_d;
  logic [H:0]       hi_d;
  logic [WIDTH:0]   res_d;

  assign s2_en = !out_valid_q || bus.out_ready;
  assign s1_en = !s1_valid_q || s2_en;

  assign bus.in_ready   = s1_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_zero   = out_zero_q;

  // Lower-half add and upper-half add with mid carry.
  always_comb begin
    lo_d  = (H+1)'(bus.in_sum[H-1:0])
          + (H+1)'(bus.in_carry[H-1:0]);
    hi_d  = (H+1)'(s1_us_q)
          + (H+1)'(s1_uc_q)
          + (H+1)'(s1_lo_q[H]);
    res_d = {hi_d, s1_lo_q[H-1:0]};
  end

  // Stage 1: low half sum plus raw upper operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_us_q    <= '0;
      s1_uc_q    <= '0;
      s1_tag_q   <= '0;
    end else if (s1_en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_lo_q  <= lo_d;
        s1_us_q  <= bus.in_sum[WIDTH-1:H];
        s1_uc_q  <= bus.in_carry[WIDTH-1:H];
        s1_tag_q <= bus.in_tag;
      end
    end
  end

  // Stage 2: full-precision result, tag and zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_zero_q   <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= res_d;
        out_tag_q    <= s1_tag_q;
        out_zero_q   <= (res_d == '0);
      end
    end
  end
endmodule

// File: tb/tb_csa_final_adder.sv
// Bench for csa_final_adder at WIDTH=8.
// Random and directed traffic against a scoreboard.
module tb_csa_final_adder;
  localparam int W = 8;
  localparam int T = 4;

  typedef struct {
    logic [W:0]   res;
    logic [T-1:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_acc;
  int   n_out;
  exp_t sb[$];

  csa_final_adder_if #(.WIDTH(W), .TAG_W(T)) bus ();

  csa_final_adder #(.WIDTH(W), .TAG_W(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             name, obs, exp);
    end
  endtask

  task automatic drive(
    input logic         v,
    input logic [W-1:0] s,
    input logic [W-1:0] c,
    input logic [T-1:0] t
  );
    bus.in_valid = v;
    bus.in_sum   = s;
    bus.in_carry = c;
    bus.in_tag   = t;
  endtask

  // Called at negedge with inputs set: score, then
  // advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      e.res = (W+1)'(bus.in_sum) + (W+1)'(bus.in_carry);
      e.tag = bus.in_tag;
      sb.push_back(e);
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("extra_out", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(bus.out_result), 32'(e.res));
        chk("tag", 32'(bus.out_tag), 32'(e.tag));
        chk("zero", 32'(bus.out_zero),
            32'(e.res == 0));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W:0] held;
  int         cyc;
  int         k;

  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;
    n_out  = 0;
    rst_n  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);

    // Reset state
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.out_result), 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid carry across halves, 2-cycle latency
    drive(1'b1, 8'hFF, 8'h01, 4'd3);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("lat1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(bus.out_valid), 32'd1);
    chk("lat2_result", 32'(bus.out_result), 32'h100);
    chk("lat2_tag", 32'(bus.out_tag), 32'd3);
    chk("lat2_zero", 32'(bus.out_zero), 32'd0);
    tick();

    // Zero and widest sum
    drive(1'b1, 8'h00, 8'h00, 4'd1);
    tick();
    drive(1'b1, 8'hFF, 8'hFF, 4'd2);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    chk("max_result", 32'(bus.out_result), 32'h1FE);
    tick();
    tick();

    // Back-to-back stream
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), T'(i));
      #1;
      chk("stream_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    tick();
    chk("stream_drain", 32'(sb.size()), 32'd0);

    // Stall: 4 ops offered, out_ready low 5 cycles
    bus.out_ready = 1'b0;
    k = n_acc;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(8'h10 + (n_acc - k)),
            W'(8'h21), T'(n_acc - k));
      tick();
      if (i == 2) held = bus.out_result;
    end
    chk("stall_acc", 32'(n_acc - k), 32'd2);
    #1;
    chk("stall_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_hold", 32'(bus.out_result), 32'(held));
    bus.out_ready = 1'b1;
    cyc = 0;
    while (n_acc - k < 4 && cyc < 20) begin
      drive(1'b1, W'(8'h10 + (n_acc - k)),
            W'(8'h21), T'(n_acc - k));
      tick();
      cyc++;
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_drain", 32'(sb.size()), 32'd0);

    // Random traffic
    k = n_acc;
    cyc = 0;
    while (n_acc - k < 1000 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), T'($urandom));
      tick();
      cyc++;
    end
    chk("rand_count", 32'(n_acc - k), 32'd1000);
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("rand_drain", 32'(sb.size()), 32'd0);
    chk("acc_vs_out", 32'(n_out), 32'(n_acc));

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h55, 8'h66, 4'd7);
    tick();
    drive(1'b1, 8'h77, 8'h08, 4'd8);
    tick();
    drive(1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h12, 8'h34, 4'd9);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("post_rst_empty", 32'(bus.out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_result", 32'(bus.out_result), 32'h046);
    chk("post_rst_tag", 32'(bus.out_tag), 32'd9);
    tick();
    tick();
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
